// File: rtl/bypass_pipe.sv
// Elastic DEPTH-stage pipeline: stage 0 decodes PASS/NOP/INVALID, later stages carry the result.
// Optional completed-op counter enabled by macro BYPASS_PIPE_COUNT_EN.
module bypass_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] opA,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             invalid_out,
  output logic [31:0]      op_count
);

  localparam int unsigned LAST = DEPTH - 1;

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] inv_q;
  logic [WIDTH-1:0] res_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [DEPTH-1:0] load;
  logic             accept;
  logic [WIDTH-1:0] res0;
  logic             inv0;

  // A stage may load when the consumer pops or any stage at or after it holds a bubble.
  always_comb begin : load_calc
    load = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      load[i] = out_ready;
      for (int unsigned j = i; j < DEPTH; j++) begin
        if (!vld_q[j]) load[i] = 1'b1;
      end
    end
  end

  always_comb begin : stage0_op
    res0 = '0;
    inv0 = 1'b0;
    case (op_sel)
      2'b00:   res0 = opA;
      2'b01:   res0 = '0;
      default: inv0 = 1'b1;
    endcase
  end

  assign in_ready = !flush && load[0];
  assign accept   = in_valid && in_ready;

  // Payload registers are zeroed whenever their stage is empty, so outputs need no masking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      inv_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
      inv_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        vld_q[0] <= accept;
        inv_q[0] <= accept && inv0;
        res_q[0] <= accept ? res0 : '0;
        tag_q[0] <= accept ? tag_in : '0;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (load[i]) begin
          vld_q[i] <= vld_q[i-1];
          inv_q[i] <= inv_q[i-1];
          res_q[i] <= res_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
  end

  assign out_valid   = vld_q[LAST];
  assign result_out  = res_q[LAST];
  assign tag_out     = tag_q[LAST];
  assign invalid_out = inv_q[LAST];

`ifdef BYPASS_PIPE_COUNT_EN
  logic        pop;
  logic [31:0] count_q;

  assign pop = vld_q[LAST] && out_ready && !flush;

  // Saturating count of delivered ops; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (pop && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign op_count = count_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_bypass_pipe.sv
// Scoreboard bench for bypass_pipe (DEPTH=3): directed ops push expectations, a monitor checks pops.
module tb_bypass_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned TAG_W = 4;

`ifdef BYPASS_PIPE_COUNT_EN
  localparam logic [31:0] CNT5 = 32'd5;
`else
  localparam logic [31:0] CNT5 = 32'd0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
    logic             inv;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] opA;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_out;
  logic [TAG_W-1:0] tag_out;
  logic             invalid_out;
  logic [31:0]      op_count;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bypass_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel), .opA(opA), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
    .tag_out(tag_out), .invalid_out(invalid_out), .op_count(op_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every delivered op must match the oldest expectation; idle outputs must read zero.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got tag %0d result 0x%0h, expected no output", tag_out, result_out);
        end else begin
          mon_e = sb.pop_front();
          check("result_out", 64'(result_out), 64'(mon_e.res));
          check("tag_out", 64'(tag_out), 64'(mon_e.tag));
          check("invalid_out", 64'(invalid_out), 64'(mon_e.inv));
        end
      end else if (!out_valid) begin
        check("idle_zero", 64'({result_out, tag_out, invalid_out}), 64'd0);
      end
    end
  end

  task automatic send(input logic [1:0] sel, input logic [WIDTH-1:0] a, input logic [TAG_W-1:0] t,
                      input logic [WIDTH-1:0] er, input logic ei, input logic exp_rdy, input string name);
    exp_t e;
    in_valid = 1'b1;
    op_sel   = sel;
    opA      = a;
    tag_in   = t;
    @(negedge clk);
    check({name, "_in_ready"}, 64'(in_ready), 64'(exp_rdy));
    if (in_ready) begin
      e = '{res: er, tag: t, inv: ei};
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int lat;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_sel = 2'b00; opA = '0; tag_in = '0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_payload", 64'({result_out, tag_out, invalid_out}), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Latency with a free-running consumer.
    send(2'b00, 32'h1234_5000, 4'd5, 32'h1234_5000, 1'b0, 1'b1, "lat");
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(DEPTH));
    drain();

    // Op decode, back to back.
    send(2'b01, 32'hFFFF_FFFF, 4'd6, 32'h0, 1'b0, 1'b1, "nop");
    send(2'b11, 32'h0000_00AA, 4'd7, 32'h0, 1'b1, 1'b1, "rsvd");
    send(2'b10, 32'h0000_0055, 4'd8, 32'h0, 1'b1, 1'b1, "inval");
    send(2'b00, 32'hDEAD_BEEF, 4'd9, 32'hDEAD_BEEF, 1'b0, 1'b1, "pass");
    drain();

    // Backpressure: fill, then a simultaneous pop and push, then a gapless drain.
    out_ready = 1'b0;
    send(2'b00, 32'h0000_0011, 4'd1, 32'h0000_0011, 1'b0, 1'b1, "fill1");
    send(2'b00, 32'h0000_0022, 4'd2, 32'h0000_0022, 1'b0, 1'b1, "fill2");
    send(2'b00, 32'h0000_0033, 4'd3, 32'h0000_0033, 1'b0, 1'b1, "fill3");
    send(2'b00, 32'h0000_0044, 4'd4, 32'h0000_0044, 1'b0, 1'b0, "full");
    out_ready = 1'b1;
    send(2'b00, 32'h0000_0044, 4'd4, 32'h0000_0044, 1'b0, 1'b1, "swap");
    out_ready = 1'b0;
    send(2'b00, 32'h0000_0099, 4'd9, 32'h0000_0099, 1'b0, 1'b0, "still_full");
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_gap", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("emptied", 64'(out_valid), 64'd0);
    check("order_done", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

    // Flush kills in-flight ops and blocks the offered one.
    out_ready = 1'b0;
    send(2'b00, 32'h0000_0066, 4'd6, 32'h0000_0066, 1'b0, 1'b1, "pre_flush1");
    send(2'b00, 32'h0000_0077, 4'd7, 32'h0000_0077, 1'b0, 1'b1, "pre_flush2");
    flush = 1'b1;
    out_ready = 1'b1;
    send(2'b00, 32'h0000_0088, 4'd8, 32'h0000_0088, 1'b0, 1'b0, "flush");
    sb.delete();
    flush = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (6) begin
      @(posedge clk); #1;
    end

    // Counter: fresh reset, five ops, flush keeps count, async reset clears it.
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(2'b00, 32'(k + 100), 4'(k), 32'(k + 100), 1'b0, 1'b1, "cnt");
    end
    drain();
    check("op_count_5", 64'(op_count), 64'(CNT5));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("op_count_flush", 64'(op_count), 64'(CNT5));
    out_ready = 1'b0;
    send(2'b00, 32'h0000_0abc, 4'd10, 32'h0000_0abc, 1'b0, 1'b1, "pre_rst1");
    send(2'b00, 32'h0000_0def, 4'd11, 32'h0000_0def, 1'b0, 1'b1, "pre_rst2");
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_op_count", 64'(op_count), 64'd0);
    check("async_rst_payload", 64'({result_out, tag_out, invalid_out}), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b00, 32'h0000_5a5a, 4'd12, 32'h0000_5a5a, 1'b0, 1'b1, "post_rst");
    drain();
    repeat (3) begin
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/bypass_pipe.md
BYPASS_PIPE -- requirements
Module: bypass_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width in bits (legal values 8..64).
REQ-002 SHALL have parameter DEPTH, default 1, meaning number of register stages (legal values 1..8).
REQ-003 SHALL have parameter TAG_W, default 4, meaning sideband tag width in bits (legal values 1..16).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous pipeline kill.
REQ-007 in_valid  input  1  an operation is offered.
REQ-008 in_ready  output  1  the block accepts the offered operation this cycle.
REQ-009 op_sel  input  2  operation: 00 PASS (LUI), 01 NOP, 10 INVALID, 11 reserved.
REQ-010 opA  input  WIDTH  operand.
REQ-011 tag_in  input  TAG_W  sideband identifier, carried unchanged.
REQ-012 out_valid  output  1  result_out, tag_out and invalid_out are valid.
REQ-013 out_ready  input  1  the consumer takes the result this cycle.
REQ-014 result_out  output  WIDTH  result.
REQ-015 tag_out  output  TAG_W  tag of the result.
REQ-016 invalid_out  output  1  the result came from an INVALID or reserved op.
REQ-017 op_count  output  32  count of completed operations (see Configuration).

Function
REQ-018 SHALL accept an op when in_valid && in_ready, and deliver it when out_valid && out_ready.
REQ-019 SHALL compute the result at stage 0:
- PASS: result = opA, invalid = 0.
- NOP: result = 0, invalid = 0.
- INVALID and reserved (11): result = 0, invalid = 1.
REQ-020 SHALL implement DEPTH stages; each stage holds valid, result, tag and invalid; the output ports are driven from the last stage.
REQ-021 A stage SHALL load from its predecessor when it is empty or when its own contents move on in the same cycle (bubbles collapse).
REQ-022 SHALL drive in_ready = !flush && (stage 0 empty || stage 0 advancing); in_ready is combinational from out_ready.
REQ-023 With out_ready held at 1, latency SHALL be exactly DEPTH cycles from acceptance to out_valid, and throughput SHALL be 1 op/cycle.
REQ-024 With out_ready = 0, the block SHALL hold the last stage stable and accept further ops until all DEPTH stages are full.
REQ-025 When full, in_ready SHALL be 0; a simultaneous output pop and input accept SHALL both occur in that cycle.
REQ-026 Ops SHALL leave in acceptance order; no op SHALL be lost or duplicated.
REQ-027 flush = 1 SHALL:
- clear every stage's valid bit at the next edge;
- accept no input that cycle;
- take precedence over out_ready, so out_valid is 0 from the next cycle.
REQ-028 Data and tag registers of invalid stages are don't-care, but result_out, tag_out and invalid_out SHALL read 0 whenever out_valid = 0.

Reset
REQ-029 While reset = 0, all stage valid bits, result_out, tag_out, invalid_out and op_count SHALL be 0 immediately (asynchronously).
REQ-030 Reset asserted mid-operation SHALL discard all in-flight ops; after reset deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-031 The macro BYPASS_PIPE_COUNT_EN controls op_count.
- Defined: op_count increments on every out_valid && out_ready, saturates at 0xFFFF_FFFF, clears on reset, and is not cleared by flush.
- Undefined: op_count is tied to 0 and no counter flops are synthesised.

Verification
REQ-032 DEPTH=3, out_ready=1; PASS opA=0x1234_5000, tag=5 at cycle 0 -> out_valid, result_out=0x1234_5000, tag_out=5, invalid_out=0 at cycle 3.
REQ-033 NOP with opA=0xFFFF_FFFF -> result_out=0, invalid_out=0; op_sel=11 with opA=0xAA -> result_out=0, invalid_out=1.
REQ-034 DEPTH=2, out_ready=0; offer 3 ops, tags 1,2,3 -> in_ready falls after 2 accepts; raise out_ready -> tags out 1,2,3 in order, no gaps.
REQ-035 Full pipe; out_ready=1 and in_valid=1 together -> one pop and one push in the same cycle, occupancy unchanged.
REQ-036 Two ops in flight; flush=1 for one cycle together with in_valid=1 -> in_ready=0, out_valid=0 next cycle, neither op emitted later.
REQ-037 BYPASS_PIPE_COUNT_EN defined; 5 completed ops -> op_count=5; reset pulse mid-stream -> op_count=0 and out_valid=0 immediately.
